// File: rtl/alu_unit_pkg.sv
// Shared ALU types for the execute stage.
// Operation encodings used by the decoder, the ALU and the bench.
package alu_unit_pkg;

  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ALU_PC   = 5'd0,
    OP_ALU_ADD  = 5'd1,
    OP_ALU_SUB  = 5'd2,
    OP_ALU_AND  = 5'd3,
    OP_ALU_OR   = 5'd4,
    OP_ALU_XOR  = 5'd5,
    OP_ALU_SLTU = 5'd6,
    OP_ALU_SLT  = 5'd7,
    OP_ALU_SLL  = 5'd8,
    OP_ALU_SRL  = 5'd9,
    OP_ALU_SRA  = 5'd10,
    OP_ALU_EQ   = 5'd11,
    OP_ALU_NEQ  = 5'd12
  } alu_op_t;

endpackage

// File: rtl/alu_comb.sv
// Pure combinational RV32I ALU function f(op, a, b).
// Reserved encodings yield zero.
module alu_comb
  import alu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  assign shamt = b[SH_W-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign eq    = a == b;

  always_comb begin
    result = '0;
    unique case (op)
      OP_ALU_PC:   result = a + WIDTH'(4);
      OP_ALU_ADD:  result = a + b;
      OP_ALU_SUB:  result = a - b;
      OP_ALU_AND:  result = a & b;
      OP_ALU_OR:   result = a | b;
      OP_ALU_XOR:  result = a ^ b;
      OP_ALU_SLTU: result = WIDTH'(lt_u);
      OP_ALU_SLT:  result = WIDTH'(lt_s);
      OP_ALU_SLL:  result = a << shamt;
      OP_ALU_SRL:  result = a >> shamt;
      OP_ALU_SRA:  result = WIDTH'($signed(a) >>> shamt);
      OP_ALU_EQ:   result = WIDTH'(eq);
      OP_ALU_NEQ:  result = WIDTH'(!eq);
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU: combinational core plus one-cycle result register.
// o_result holds its value while idle; o_valid tracks i_valid.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = ALU_OP_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  alu_op_t          i_alu_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid
);

  logic [OP_WIDTH-1:0] op_raw;
  logic [WIDTH-1:0]    comb_res;

  assign op_raw = i_alu_op;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op     (alu_op_t'(op_raw)),
    .a      (i_a),
    .b      (i_b),
    .result (comb_res)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_result <= comb_res;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed and random checks for alu_unit.
// Expected values are hand-computed or from a local reference model.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  alu_op_t     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] res;
  logic        res_vld;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_unit #(
    .WIDTH    (32),
    .OP_WIDTH (5)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (vld),
    .i_alu_op (op),
    .i_a      (a),
    .i_b      (b),
    .o_result (res),
    .o_valid  (res_vld)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    logic [4:0]  s;
    logic [31:0] fill;
    logic        slt;
    s = y[4:0];
    if (x[31] != y[31]) slt = x[31];
    else slt = (x < y);
    fill = (x[31] && s != 0) ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (o)
      5'd0:  return x + 32'd4;
      5'd1:  return x + y;
      5'd2:  return x + ~y + 32'd1;
      5'd3:  return x & y;
      5'd4:  return x | y;
      5'd5:  return x ^ y;
      5'd6:  return {31'd0, x < y};
      5'd7:  return {31'd0, slt};
      5'd8:  return x << s;
      5'd9:  return x >> s;
      5'd10: return (x >> s) | fill;
      5'd11: return {31'd0, x == y};
      5'd12: return {31'd0, x != y};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    vld = 1'b1;
    op  = alu_op_t'(o);
    a   = x;
    b   = y;
  endtask

  task automatic run1(input string tag, input logic [4:0] o,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp);
    drive(o, x, y);
    @(posedge clk); #1;
    chk({tag, "_v"}, {31'd0, res_vld}, 32'd1);
    chk(tag, res, exp);
  endtask

  initial begin
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_op;
    rst = 1'b1;
    drive(5'd1, 32'd5, 32'd7);
    @(posedge clk); #1;
    chk("rst_res", res, 32'h0);
    chk("rst_vld", {31'd0, res_vld}, 32'd0);
    rst = 1'b0;

    run1("add",  5'd1,  32'd1, 32'd1, 32'd2);
    run1("and",  5'd3,  32'd1, 32'd2, 32'd0);
    run1("sub",  5'd2,  32'd0, 32'd1, 32'hFFFF_FFFF);
    run1("pc",   5'd0,  32'h0000_1000, 32'd0, 32'h0000_1004);
    run1("or",   5'd4,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    run1("xor",  5'd5,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    run1("slt",  5'd7,  32'hFFFF_FFFF, 32'd1, 32'd1);
    run1("sltu", 5'd6,  32'hFFFF_FFFF, 32'd1, 32'd0);
    run1("eq",   5'd11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd1);
    run1("neq",  5'd12, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0);
    run1("sll",  5'd8,  32'd1, 32'h0000_0025, 32'h0000_0020);
    run1("srl",  5'd9,  32'h8000_0000, 32'd31, 32'd1);
    run1("sra",  5'd10, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run1("sra0", 5'd10, 32'h8765_4321, 32'h0000_0020, 32'h8765_4321);
    run1("sll0", 5'd8,  32'h8765_4321, 32'd0, 32'h8765_4321);
    run1("add_wrap", 5'd1, 32'hFFFF_FFFF, 32'd2, 32'd1);

    run1("b2b_0", 5'd1, 32'd10, 32'd20, 32'd30);
    run1("b2b_1", 5'd2, 32'd50, 32'd8,  32'd42);
    run1("b2b_2", 5'd5, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);

    vld = 1'b0;
    op  = alu_op_t'(5'd1);
    a   = 32'd3;
    b   = 32'd4;
    @(posedge clk); #1;
    chk("idle_vld", {31'd0, res_vld}, 32'd0);
    chk("idle_hold", res, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("idle_hold2", res, 32'hFFFF_FFFF);

    run1("rsv13", 5'd13, 32'h1234_5678, 32'h1, 32'h0);
    run1("rsv31", 5'd31, 32'h1234_5678, 32'h1, 32'h0);

    for (int i = 0; i < 10000; i++) begin
      r_op = 5'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      if (i % 7 == 0) r_b = r_a;
      run1("rand", r_op, r_a, r_b, ref_alu(r_op, r_a, r_b));
    end

    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_res", res, 32'h0);
    chk("rst2_vld", {31'd0, res_vld}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
